// File: rtl/packet_splitter_if.sv
// Core-side send port and NoC injection port of the packet splitter.
// The core/NoC side uses the master modport; the splitter uses the slave modport.
interface packet_splitter_if #(
  parameter int NODE_W  = 3,
  parameter int ID_W    = 5,
  parameter int PAYLOAD = 32,
  parameter int FLIT_W  = 22
);
  logic               pkt_valid;
  logic               pkt_ready;
  logic [PAYLOAD-1:0] pkt_data;
  logic [NODE_W-1:0]  pkt_dest;
  logic [ID_W-1:0]    pkt_id_out;
  logic [FLIT_W-1:0]  flit_out;
  logic               flit_ready;
  logic               busy;

  modport master (
    output pkt_valid, pkt_data, pkt_dest, flit_ready,
    input  pkt_ready, pkt_id_out, flit_out, busy
  );

  modport slave (
    input  pkt_valid, pkt_data, pkt_dest, flit_ready,
    output pkt_ready, pkt_id_out, flit_out, busy
  );
endinterface

// File: rtl/packet_splitter.sv
// Transmit side of the flit link: queues whole packets, tags them with
// source/destination/id and serialises each into FLIT_COUNT flits, MS chunk first.
//
// state | meaning
// IDLE  | no packet loaded, flit valid bit low
// SEND  | output register holds the FIFO head, flit idx_q is being offered
//
// The head entry stays in the FIFO until its last flit is taken, so the FIFO
// depth is the total number of packets the block can hold.
module packet_splitter #(
  parameter int NODE_COUNT      = 8,
  parameter int NODE_ID         = 0,
  parameter int PACKET_ID_WIDTH = 5,
  parameter int QUEUE_DEPTH     = 4,
  parameter int PAYLOAD         = 32,
  parameter int FLIT_PAYLOAD    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce,
  packet_splitter_if.slave bus
);
  localparam int NODE_W     = $clog2(NODE_COUNT);
  localparam int ID_W       = PACKET_ID_WIDTH;
  localparam int FLIT_COUNT = (PAYLOAD + FLIT_PAYLOAD - 1) / FLIT_PAYLOAD;
  localparam int IDX_W      = (FLIT_COUNT > 1) ? $clog2(FLIT_COUNT) : 1;
  localparam int PAD_TOTAL  = FLIT_COUNT * FLIT_PAYLOAD;
  localparam int PAD_W      = PAD_TOTAL - PAYLOAD;
  localparam int AW         = $clog2(QUEUE_DEPTH);
  localparam int ENTRY_W    = PAYLOAD + NODE_W + ID_W;
  localparam int FLIT_W     = 1 + NODE_W + IDX_W + FLIT_PAYLOAD + ID_W + NODE_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FLIT_COUNT - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t state_q, state_d;

  logic [ENTRY_W-1:0] mem_q [QUEUE_DEPTH];
  logic [AW:0]        wr_ptr_q, rd_ptr_q, rd_nxt, count;
  logic               full, empty, has_next;
  logic               push, pop;
  logic [ID_W-1:0]    id_cnt_q;

  logic [PAYLOAD-1:0] pkt_q, pkt_d;
  logic [NODE_W-1:0]  dest_q, dest_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [NODE_W-1:0]  start_q, start_d;
  logic [IDX_W-1:0]   idx_q, idx_d;

  logic [ENTRY_W-1:0] head_entry, next_entry;
  logic [PAD_TOTAL-1:0] padded, shifted;
  logic [FLIT_PAYLOAD-1:0] chunk;

  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign count    = wr_ptr_q - rd_ptr_q;
  assign has_next = (count > (AW+1)'(1));
  assign rd_nxt   = rd_ptr_q + (AW+1)'(1);

  assign head_entry = mem_q[rd_ptr_q[AW-1:0]];
  assign next_entry = mem_q[rd_nxt[AW-1:0]];

  // Ready is forced low while reset is held; a full FIFO never writes through.
  assign bus.pkt_ready  = rst_n & ~full;
  assign push           = ce & bus.pkt_valid & bus.pkt_ready;
  assign bus.pkt_id_out = id_cnt_q;
  assign bus.busy       = ~empty | (state_q == SEND);

  // Packet FIFO storage and pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < QUEUE_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q[AW-1:0]] <= {bus.pkt_data, bus.pkt_dest, id_cnt_q};
        wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      end
      if (pop) rd_ptr_q <= rd_nxt;
    end
  end

  // Packet id counter, wraps naturally at 2^ID_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) id_cnt_q <= '0;
    else if (push) id_cnt_q <= id_cnt_q + ID_W'(1);
  end

  // FSM state and output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pkt_q   <= '0;
      dest_q  <= '0;
      id_q    <= '0;
      start_q <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      pkt_q   <= pkt_d;
      dest_q  <= dest_d;
      id_q    <= id_d;
      start_q <= start_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state: load the head, step through flits, reload without a bubble.
  always_comb begin
    state_d = state_q;
    pkt_d   = pkt_q;
    dest_d  = dest_q;
    id_d    = id_q;
    start_d = start_q;
    idx_d   = idx_q;
    pop     = 1'b0;
    if (ce) begin
      case (state_q)
        IDLE: begin
          if (!empty) begin
            {pkt_d, dest_d, id_d} = head_entry;
            start_d = NODE_W'(NODE_ID);
            idx_d   = '0;
            state_d = SEND;
          end
        end
        SEND: begin
          if (bus.flit_ready) begin
            if (idx_q == LAST_IDX) begin
              pop = 1'b1;
              if (has_next) begin
                {pkt_d, dest_d, id_d} = next_entry;
                idx_d = '0;
              end else begin
                state_d = IDLE;
              end
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Chunk select: left-align the packet so a short last chunk is zero-padded low.
  always_comb begin
    padded  = PAD_TOTAL'(pkt_q) << PAD_W;
    shifted = padded << (int'(idx_q) * FLIT_PAYLOAD);
    chunk   = shifted[PAD_TOTAL-1 -: FLIT_PAYLOAD];
  end

  assign bus.flit_out = {(state_q == SEND), dest_q, idx_q, chunk, id_q, start_q};

endmodule

// File: tb/tb_packet_splitter.sv
// Scoreboard bench for packet_splitter at defaults with NODE_ID=3.
module tb_packet_splitter;
  localparam int NODE_W  = 3;
  localparam int ID_W    = 5;
  localparam int PAYLOAD = 32;
  localparam int FLIT_W  = 22;
  localparam int NODE_ID = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ce = 1'b1;
  always #5 clk = ~clk;

  packet_splitter_if #(.NODE_W(NODE_W), .ID_W(ID_W), .PAYLOAD(PAYLOAD), .FLIT_W(FLIT_W)) bus();

  packet_splitter #(
    .NODE_COUNT(8), .NODE_ID(NODE_ID), .PACKET_ID_WIDTH(ID_W),
    .QUEUE_DEPTH(4), .PAYLOAD(PAYLOAD), .FLIT_PAYLOAD(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .bus(bus.slave)
  );

  int passed = 0;
  int total  = 0;
  logic [FLIT_W-1:0] exp_q[$];
  logic [ID_W-1:0]   exp_id = '0;

  function automatic logic [FLIT_W-1:0] exp_flit(logic [31:0] d, logic [2:0] dest,
                                                 logic [4:0] id, int idx);
    logic [7:0] ch;
    ch = 8'(d >> (24 - 8 * idx));
    return {1'b1, dest, 2'(idx), ch, id, 3'(NODE_ID)};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=%h required=%h", name, act, exp);
  endtask

  // Monitor: every flit taken by the downstream must be the next expected one.
  always @(negedge clk) begin
    if (rst_n && ce && bus.flit_out[FLIT_W-1] && bus.flit_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_flit actual=%h required=none", bus.flit_out);
      end else begin
        chk("flit", 32'(bus.flit_out), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic send(input logic [31:0] d, input logic [2:0] dest);
    int n = 0;
    @(negedge clk);
    bus.pkt_valid = 1'b1;
    bus.pkt_data  = d;
    bus.pkt_dest  = dest;
    while (!(bus.pkt_ready && ce) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      total++;
      $display("FAIL send_timeout actual=not_ready required=accept");
      bus.pkt_valid = 1'b0;
      return;
    end
    chk("pkt_id", 32'(bus.pkt_id_out), 32'(exp_id));
    for (int i = 0; i < 4; i++) exp_q.push_back(exp_flit(d, dest, exp_id, i));
    exp_id++;
    @(posedge clk);
    #1 bus.pkt_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || bus.busy) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      total++;
      $display("FAIL drain_timeout actual=busy required=idle");
    end
    chk("idle_valid", 32'(bus.flit_out[FLIT_W-1]), 32'd0);
  endtask

  // Waits until the flit with the given id and index is on the output.
  task automatic wait_flit(input logic [4:0] id, input int idx);
    int n = 0;
    @(negedge clk);
    while (!(bus.flit_out[21] && bus.flit_out[17:16] == 2'(idx) && bus.flit_out[7:3] == id)
           && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      total++;
      $display("FAIL wait_flit_timeout actual=%h required=id%0d_idx%0d", bus.flit_out, id, idx);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    exp_q.delete();
    exp_id = '0;
    @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    logic [4:0] id_t;
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] id_t;
    bus.pkt_valid  = 1'b0;
    bus.pkt_data   = '0;
    bus.pkt_dest   = '0;
    bus.flit_ready = 1'b0;

    // Reset state
    #12;
    chk("rst_pkt_ready", 32'(bus.pkt_ready), 32'd0);
    chk("rst_flit_out", 32'(bus.flit_out), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_pkt_id", 32'(bus.pkt_id_out), 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    #1 chk("rel_pkt_ready", 32'(bus.pkt_ready), 32'd1);

    // 1: single packet, latency, consecutive flits, busy falls
    bus.flit_ready = 1'b1;
    send(32'hA1B2C3D4, 3'd5);
    @(negedge clk);
    chk("t1_not_yet_valid", 32'(bus.flit_out[21]), 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t1_flit_seq", 32'(bus.flit_out), 32'(exp_flit(32'hA1B2C3D4, 3'd5, 5'd0, k)));
    end
    @(negedge clk);
    chk("t1_busy_fall", 32'(bus.busy), 32'd0);
    wait_drain();

    // 2: stall on flit 1 for 3 cycles
    bus.flit_ready = 1'b0;
    id_t = exp_id;
    send(32'h11223344, 3'd2);
    wait_flit(id_t, 0);
    @(posedge clk);
    #1 bus.flit_ready = 1'b1;
    @(posedge clk);
    #1 bus.flit_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("t2_hold", 32'(bus.flit_out), 32'(exp_flit(32'h11223344, 3'd2, id_t, 1)));
    end
    @(posedge clk);
    #1 bus.flit_ready = 1'b1;
    wait_drain();

    // 3: fill the FIFO while stalled, then release
    do_reset();
    bus.flit_ready = 1'b0;
    send(32'h01020304, 3'd1);
    send(32'h05060708, 3'd2);
    send(32'h090A0B0C, 3'd3);
    send(32'h0D0E0F10, 3'd4);
    @(negedge clk);
    chk("t3_full_ready", 32'(bus.pkt_ready), 32'd0);
    chk("t3_busy", 32'(bus.busy), 32'd1);
    fork
      send(32'h99887766, 3'd7);
      begin
        repeat (3) @(posedge clk);
        #1 bus.flit_ready = 1'b1;
      end
    join
    wait_drain();

    // 4: 33 packets, id wrap
    do_reset();
    bus.flit_ready = 1'b1;
    for (int i = 0; i < 33; i++) send(32'hDEADBEEF ^ (32'h01010101 * 32'(i)), 3'(i));
    wait_drain();

    // 5: clock enable low mid-packet
    id_t = exp_id;
    send(32'hCAFEF00D, 3'd6);
    wait_flit(id_t, 1);
    @(posedge clk);
    #1 ce = 1'b0;
    bus.pkt_valid = 1'b1;
    bus.pkt_data  = 32'hBAD0BAD0;
    bus.pkt_dest  = 3'd1;
    repeat (2) begin
      @(negedge clk);
      chk("t5_ce_hold", 32'(bus.flit_out), 32'(exp_flit(32'hCAFEF00D, 3'd6, id_t, 2)));
    end
    chk("t5_id_frozen", 32'(bus.pkt_id_out), 32'(exp_id));
    @(posedge clk);
    #1 bus.pkt_valid = 1'b0;
    ce = 1'b1;
    wait_drain();

    // 6: async reset in the middle of packet 2
    send(32'h13579BDF, 3'd1);
    id_t = exp_id;
    send(32'h2468ACE0, 3'd4);
    wait_flit(id_t, 1);
    #2 rst_n = 1'b0;
    exp_q.delete();
    exp_id = '0;
    #1;
    chk("t6_flit_zero", 32'(bus.flit_out), 32'd0);
    chk("t6_busy_zero", 32'(bus.busy), 32'd0);
    chk("t6_ready_zero", 32'(bus.pkt_ready), 32'd0);
    chk("t6_id_zero", 32'(bus.pkt_id_out), 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    send(32'h0BADCAFE, 3'd7);
    wait_drain();

    // 7: random downstream stalls
    fork
      for (int i = 0; i < 8; i++) send(32'h31415926 + 32'(i) * 32'h10203040, 3'(i + 2));
      begin
        repeat (60) begin
          @(posedge clk);
          #1 bus.flit_ready = 1'($urandom_range(0, 1));
        end
        bus.flit_ready = 1'b1;
      end
    join
    wait_drain();

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
